// File: rtl/fir_mac_sequencer_if.sv
// Sample, coefficient, MAC and output signals of the FIR MAC sequencer.
// master: source/MAC/sink side, slave: the sequencer.
interface fir_mac_sequencer_if;
  logic       din_valid;
  logic [7:0] din;
  logic       din_ready;
  logic       coef_wr;
  logic [1:0] coef_addr;
  logic [7:0] coef_data;
  logic       mac_enable;
  logic [7:0] h_0;
  logic [7:0] h_1;
  logic [7:0] h_2;
  logic [7:0] h_3;
  logic [7:0] data_0;
  logic [7:0] data_1;
  logic [7:0] data_2;
  logic [7:0] data_3;
  logic [9:0] mac_data_out;
  logic       mac_done;
  logic       dout_valid;
  logic [9:0] dout;
  logic       dout_ready;
  logic       err_timeout;
  logic       err_clr;

  modport master (
    output din_valid, din, coef_wr, coef_addr, coef_data,
    output mac_data_out, mac_done, dout_ready, err_clr,
    input  din_ready, mac_enable, h_0, h_1, h_2, h_3,
    input  data_0, data_1, data_2, data_3,
    input  dout_valid, dout, err_timeout
  );

  modport slave (
    input  din_valid, din, coef_wr, coef_addr, coef_data,
    input  mac_data_out, mac_done, dout_ready, err_clr,
    output din_ready, mac_enable, h_0, h_1, h_2, h_3,
    output data_0, data_1, data_2, data_3,
    output dout_valid, dout, err_timeout
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Initiator-side controller for the 4-tap FIR MAC: delay line,
// coefficient bank, MAC handshake and a one-entry output buffer.
module fir_mac_sequencer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                clk,
  input logic                rst_n,
  fir_mac_sequencer_if.slave bus
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [9:0]    result;
  logic          accept;
  logic          slot_free;
  logic          load_run;
  logic          load_stall;
  logic          timeout;

  always_comb begin
    accept     = bus.din_valid && (state == IDLE);
    slot_free  = !bus.dout_valid || bus.dout_ready;
    load_run   = (state == RUN) && bus.mac_done && slot_free;
    load_stall = (state == STALL) && bus.dout_ready;
    // mac_done in the last cycle still wins over the abort
    timeout    = (state == RUN) && !bus.mac_done && (cnt == LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN: begin
        if (bus.mac_done) state_nxt = slot_free ? IDLE : STALL;
        else if (timeout) state_nxt = IDLE;
      end
      STALL:   if (bus.dout_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.din_ready  = (state == IDLE);
    bus.mac_enable = (state == RUN);
  end

  // coefficients only move while no MAC is in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.h_0 <= '0;
      bus.h_1 <= '0;
      bus.h_2 <= '0;
      bus.h_3 <= '0;
    end else if (bus.coef_wr && state == IDLE) begin
      unique case (bus.coef_addr)
        2'd0: bus.h_0 <= bus.coef_data;
        2'd1: bus.h_1 <= bus.coef_data;
        2'd2: bus.h_2 <= bus.coef_data;
        2'd3: bus.h_3 <= bus.coef_data;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.data_0 <= '0;
      bus.data_1 <= '0;
      bus.data_2 <= '0;
      bus.data_3 <= '0;
    end else if (accept) begin
      bus.data_3 <= bus.data_2;
      bus.data_2 <= bus.data_1;
      bus.data_1 <= bus.data_0;
      bus.data_0 <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (accept)          cnt <= '0;
    else if (state == RUN)    cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      result <= '0;
    else if (state == RUN && bus.mac_done)
      result <= bus.mac_data_out;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dout       <= '0;
      bus.dout_valid <= 1'b0;
    end else if (load_run) begin
      bus.dout       <= bus.mac_data_out;
      bus.dout_valid <= 1'b1;
    end else if (load_stall) begin
      bus.dout       <= result;
      bus.dout_valid <= 1'b1;
    end else if (bus.dout_valid && bus.dout_ready) begin
      bus.dout_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           bus.err_timeout <= 1'b0;
    else if (timeout)     bus.err_timeout <= 1'b1;
    else if (bus.err_clr) bus.err_timeout <= 1'b0;
  end

endmodule
